l1_mem_bus_arbiter: RTL

//  Shares the single L1-to-memory burst bus between the L1I refill port and the L1D

---
 rtl/l1_mem_bus_arbiter_pkg.sv | 16 +
 rtl/l1_burst_counter.sv | 38 +++
 rtl/l1_mem_bus_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/l1_mem_bus_arbiter_pkg.sv
// rtl/l1_mem_bus_arbiter_pkg.sv - shared states, owner encoding and default burst length
package l1_mem_bus_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_OWN_I = 2'd1;
   localparam logic [1:0] ARB_OWN_D = 2'd2;
   localparam logic [1:0] ARB_TURN  = 2'd3;

   localparam int L1_BURST_LEN = 4;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

endpackage

// File: rtl/l1_burst_counter.sv
// rtl/l1_burst_counter.sv - beat counter for one cache-line burst, flags the final beat
module l1_burst_counter
   import l1_mem_bus_arbiter_pkg::*;
#(
   parameter int BURST_LEN = L1_BURST_LEN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic beat,
   output logic last
);

   localparam int CW = $clog2(BURST_LEN);

   logic [CW-1:0] cnt_q, cnt_d;

   assign last = beat && (cnt_q == CW'(BURST_LEN - 1));

   // BURST_LEN is a power of two, so the natural roll-over is the wrap to 0
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (beat) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/l1_mem_bus_arbiter.sv
// rtl/l1_mem_bus_arbiter.sv - shares the L1-to-memory burst bus between L1I refill and L1D
module l1_mem_bus_arbiter
   import l1_mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int BURST_LEN = L1_BURST_LEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_req,
   input  logic              d_rd,
   input  logic              d_lock,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              mem_beat,
   output logic              mem_req,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              i_gnt,
   output logic              d_gnt,
   output logic              i_done,
   output logic              d_done
);

   logic [1:0] state_q, state_d;
   owner_e     last_owner_q, last_owner_d;
   logic       lock_used_q, lock_used_d;
   logic       own_i, own_d, own, last;

   assign own_i = (state_q == ARB_OWN_I);
   assign own_d = (state_q == ARB_OWN_D);
   assign own   = own_i | own_d;

   l1_burst_counter #(
      .BURST_LEN(BURST_LEN)
   ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (!own),
      .beat (mem_beat && own),
      .last (last)
   );

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      lock_used_d  = lock_used_q;
      case (state_q)
         ARB_IDLE: begin
            if (i_req && d_req) begin
               state_d = (last_owner_q == OWNER_D) ? ARB_OWN_I : ARB_OWN_D;
            end else if (i_req) begin
               state_d = ARB_OWN_I;
            end else if (d_req) begin
               state_d = ARB_OWN_D;
            end
         end
         ARB_OWN_I: begin
            if (last) begin
               state_d      = ARB_TURN;
               last_owner_d = OWNER_I;
            end
         end
         ARB_OWN_D: begin
            // only one locked follow-on burst per ownership so L1I cannot starve
            if (last) begin
               last_owner_d = OWNER_D;
               if (d_lock && !lock_used_q) begin
                  lock_used_d = 1'b1;
               end else begin
                  state_d     = ARB_TURN;
                  lock_used_d = 1'b0;
               end
            end
         end
         ARB_TURN: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         last_owner_q <= OWNER_D;
         lock_used_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         lock_used_q  <= lock_used_d;
      end
   end

   assign i_gnt    = own_i;
   assign d_gnt    = own_d;
   assign mem_req  = own;
   assign mem_rd   = own_i | (own_d & d_rd);
   assign mem_addr = own_i ? i_addr : (own_d ? d_addr : '0);
   assign i_done   = own_i & last;
   assign d_done   = own_d & last;

endmodule
